// File: rtl/udp_packet_sender.sv
// udp_packet_sender: FIFO-buffered UDP packetizer for the UPL output side.
// Ports: clk, reset (sync, active-high); cfg_src_ip, cfg_dst_ip,
//   cfg_src_port, cfg_dst_port (sampled at packet start);
//   in_valid/in_data/in_ready (user word stream); flush (send-now pulse);
//   UPLout_Request/UPLout_Ack/UPLout_Enable/UPLout_Data (UPL framing);
//   busy (not idle); pkt_count (packets sent, wraps).
// Option: define UDPSEND_SEQNUM_EN to prepend a 32-bit sequence number
//   to every payload (extra SEQ state, byte field counts it).
module udp_packet_sender #(
  parameter int DEPTH_LOG2 = 5,
  parameter int MAX_WORDS  = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cfg_src_ip,
  input  logic [31:0] cfg_dst_ip,
  input  logic [15:0] cfg_src_port,
  input  logic [15:0] cfg_dst_port,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        flush,
  output logic        UPLout_Request,
  input  logic        UPLout_Ack,
  output logic        UPLout_Enable,
  output logic [31:0] UPLout_Data,
  output logic        busy,
  output logic [15:0] pkt_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int TW    = $clog2(TIMEOUT) + 1;
`ifdef UDPSEND_SEQNUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HDR_DST,
    S_HDR_PORT,
    S_HDR_BYTES,
    S_SEQ,
    S_DATA,
    S_END
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic                  push;
  logic                  pop;

  logic                  flush_lat;
  logic [TW-1:0]         timer;
  logic                  trigger;
  logic                  start;
  logic [CW-1:0]         n_take;
  logic [CW-1:0]         rem;

  logic [31:0]           src_lat;
  logic [31:0]           dst_lat;
  logic [15:0]           sport_lat;
  logic [15:0]           dport_lat;
  logic [31:0]           byte_cnt;

`ifdef UDPSEND_SEQNUM_EN
  logic [31:0]           seq;
`endif

  logic                  req_nxt;
  logic                  en_nxt;
  logic [31:0]           data_nxt;

  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == S_DATA);
  assign busy     = (state != S_IDLE);

  // Guarding on a non-empty FIFO keeps N from ever being zero.
  assign trigger = (count != '0) &&
                   ((count >= CW'(MAX_WORDS)) ||
                    flush_lat ||
                    (timer == TW'(TIMEOUT - 1)));
  assign start   = (state == S_IDLE) && trigger;

  assign n_take = (count >= CW'(MAX_WORDS)) ? CW'(MAX_WORDS) : count;

  // rem still holds N while the byte field is formed.
  assign byte_cnt = (32'(rem) + 32'(EXTRA)) << 2;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      UPLout_Request <= 1'b0;
      UPLout_Enable  <= 1'b0;
      UPLout_Data    <= '0;
    end else begin
      state          <= state_nxt;
      UPLout_Request <= req_nxt;
      UPLout_Enable  <= en_nxt;
      UPLout_Data    <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (trigger) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (UPLout_Ack) begin
          state_nxt = S_HDR_DST;
        end
      end
      S_HDR_DST: begin
        state_nxt = S_HDR_PORT;
      end
      S_HDR_PORT: begin
        state_nxt = S_HDR_BYTES;
      end
      S_HDR_BYTES: begin
`ifdef UDPSEND_SEQNUM_EN
        state_nxt = S_SEQ;
`else
        state_nxt = S_DATA;
`endif
      end
      S_SEQ: begin
        state_nxt = S_DATA;
      end
      S_DATA: begin
        if (rem == CW'(1)) begin
          state_nxt = S_END;
        end
      end
      S_END: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    req_nxt  = UPLout_Request;
    en_nxt   = UPLout_Enable;
    data_nxt = UPLout_Data;
    unique case (state)
      S_IDLE: begin
        en_nxt = 1'b0;
        if (trigger) begin
          req_nxt = 1'b1;
        end
      end
      S_REQ: begin
        if (UPLout_Ack) begin
          req_nxt  = 1'b0;
          en_nxt   = 1'b1;
          data_nxt = src_lat;
        end
      end
      S_HDR_DST: begin
        data_nxt = dst_lat;
      end
      S_HDR_PORT: begin
        data_nxt = {sport_lat, dport_lat};
      end
      S_HDR_BYTES: begin
        data_nxt = byte_cnt;
      end
      S_SEQ: begin
`ifdef UDPSEND_SEQNUM_EN
        data_nxt = seq;
`endif
      end
      S_DATA: begin
        data_nxt = mem[rd_ptr];
      end
      S_END: begin
        en_nxt   = 1'b0;
        data_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      flush_lat <= 1'b0;
      timer     <= '0;
      rem       <= '0;
      src_lat   <= '0;
      dst_lat   <= '0;
      sport_lat <= '0;
      dport_lat <= '0;
      pkt_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end

      // An empty FIFO drops a stale flush so it cannot fire later.
      if (start) begin
        flush_lat <= 1'b0;
      end else if (flush && (count != '0)) begin
        flush_lat <= 1'b1;
      end else if (count == '0) begin
        flush_lat <= 1'b0;
      end

      if (push || start || (count == '0)) begin
        timer <= '0;
      end else if (state == S_IDLE) begin
        timer <= timer + TW'(1);
      end

      if (start) begin
        rem       <= n_take;
        src_lat   <= cfg_src_ip;
        dst_lat   <= cfg_dst_ip;
        sport_lat <= cfg_src_port;
        dport_lat <= cfg_dst_port;
      end else if (pop) begin
        rem <= rem - CW'(1);
      end

      if (state == S_END) begin
        pkt_count <= pkt_count + 16'd1;
      end
    end
  end

`ifdef UDPSEND_SEQNUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      seq <= '0;
    end else if (state == S_END) begin
      seq <= seq + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_udp_packet_sender.sv
// tb_udp_packet_sender: directed bench for udp_packet_sender with a
// queue-based packet model checked every cycle.
module tb_udp_packet_sender;

  localparam int DEPTH     = 32;
  localparam int MAX_WORDS = 16;
  localparam int TIMEOUT   = 1024;
`ifdef UDPSEND_SEQNUM_EN
  localparam int SEQW = 1;
`else
  localparam int SEQW = 0;
`endif

  localparam logic [31:0] SRC = 32'h0A00_0001;
  localparam logic [31:0] DST = 32'h0A00_0002;
  localparam logic [15:0] SP  = 16'h4000;
  localparam logic [15:0] DP  = 16'h4001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        UPLout_Request;
  logic        UPLout_Ack = 1'b0;
  logic        UPLout_Enable;
  logic [31:0] UPLout_Data;
  logic        busy;
  logic [15:0] pkt_count;

  udp_packet_sender #(
    .DEPTH_LOG2(5),
    .MAX_WORDS(MAX_WORDS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_src_ip(SRC),
    .cfg_dst_ip(DST),
    .cfg_src_port(SP),
    .cfg_dst_port(DP),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .flush(flush),
    .UPLout_Request(UPLout_Request),
    .UPLout_Ack(UPLout_Ack),
    .UPLout_Enable(UPLout_Enable),
    .UPLout_Data(UPLout_Data),
    .busy(busy),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Downstream grant: tied high, or raised after Request has been
  // held for more than ack_delay cycles.
  bit ack_tied  = 1'b1;
  int ack_delay = 0;
  int req_wait  = 0;

  always @(negedge clk) begin
    if (UPLout_Request) req_wait++;
    else req_wait = 0;
    UPLout_Ack = ack_tied || (UPLout_Request && req_wait > ack_delay);
  end

  // Model state.
  logic [31:0] q[$];
  int          cnt = 0;
  int          exp_n = 0;
  bit          in_pkt = 1'b0;
  int          k = 0;
  int          model_pkt = 0;
  logic [31:0] seq_m = '0;
  logic        prev_req = 1'b0;
  logic        prev_en = 1'b0;
  int          cyc = 0;
  int          req_rises = 0;
  int          req_rise_cyc = 0;
  int          last_push_cyc = 0;
  logic [31:0] obs[$];
  logic [31:0] bytes_log[$];
  int          len_log[$];

  always begin
    logic        rst_s;
    logic        v_s;
    logic        ack_s;
    logic [31:0] d_s;
    logic [31:0] e;
    int          cnt0;
    @(posedge clk);
    cyc++;
    rst_s = reset;
    v_s   = in_valid;
    d_s   = in_data;
    ack_s = UPLout_Ack;
    cnt0  = cnt;
    #1;
    if (rst_s) begin
      q.delete();
      cnt = 0;
      in_pkt = 1'b0;
      k = 0;
      model_pkt = 0;
      seq_m = '0;
      chk("rst_req", 32'(UPLout_Request), 32'd0);
      chk("rst_en", 32'(UPLout_Enable), 32'd0);
      chk("rst_data", UPLout_Data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pkts", 32'(pkt_count), 32'd0);
      chk("rst_rdy", 32'(in_ready), 32'd1);
    end else begin
      if (v_s && cnt0 < DEPTH) begin
        q.push_back(d_s);
        cnt++;
        last_push_cyc = cyc;
      end
      if (UPLout_Request && !prev_req) begin
        chk("req_in_pkt", 32'(in_pkt), 32'd0);
        chk("req_nonempty", 32'(cnt0 != 0), 32'd1);
        exp_n = (cnt0 < MAX_WORDS) ? cnt0 : MAX_WORDS;
        in_pkt = 1'b1;
        k = 0;
        req_rises++;
        req_rise_cyc = cyc;
      end
      if (UPLout_Enable && !prev_en) begin
        chk("en_after_ack", 32'(prev_req && ack_s), 32'd1);
      end
      if (UPLout_Enable) begin
        e = '0;
        if (k == 0) e = SRC;
        else if (k == 1) e = DST;
        else if (k == 2) e = {SP, DP};
        else if (k == 3) e = 32'((exp_n + SEQW) * 4);
        else if (k == 4 && SEQW == 1) e = seq_m;
        else if (k < 4 + SEQW + exp_n && q.size() > 0) begin
          e = q.pop_front();
          cnt--;
        end else begin
          chk("pkt_overrun", 32'(k), 32'(3 + SEQW + exp_n));
        end
        if (k == 3) bytes_log.push_back(UPLout_Data);
        chk("data", UPLout_Data, e);
        obs.push_back(UPLout_Data);
        k++;
      end else begin
        if (prev_en) begin
          chk("pkt_len", 32'(k), 32'(4 + SEQW + exp_n));
          len_log.push_back(k);
          in_pkt = 1'b0;
          model_pkt++;
          seq_m = seq_m + 32'd1;
        end
        chk("idle_data", UPLout_Data, 32'd0);
      end
      chk("req_en_excl", 32'(UPLout_Request && UPLout_Enable), 32'd0);
      chk("busy", 32'(busy), 32'(UPLout_Request || UPLout_Enable));
      chk("pkt_count", 32'(pkt_count), 32'(model_pkt % 65536));
      chk("in_ready", 32'(in_ready), 32'(cnt < DEPTH));
    end
    prev_req = UPLout_Request;
    prev_en  = UPLout_Enable;
  end

  task automatic write_words(input int n, input logic [31:0] base,
                             output int first_full);
    int i;
    int tries;
    logic rdy;
    i = 0;
    tries = 0;
    first_full = -1;
    while (i < n && tries < 5000) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = base + 32'(i);
      rdy = in_ready;
      @(posedge clk);
      tries++;
      if (rdy) i++;
      else if (first_full < 0) first_full = i;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("write_stall", 32'(i), 32'(n));
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (!(cnt == 0 && !busy) && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(t < budget), 32'd1);
  endtask

  task automatic clear_logs();
    obs.delete();
    bytes_log.delete();
    len_log.delete();
  endtask

  initial begin
    int ff;
    int r0;
    int t;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Full packet from the word-count trigger.
    clear_logs();
    write_words(16, 32'h1, ff);
    drain(200);
    chk("t1_len", 32'(obs.size()), 32'(20 + SEQW));
    chk("t1_src", obs[0], 32'h0A00_0001);
    chk("t1_dst", obs[1], 32'h0A00_0002);
    chk("t1_port", obs[2], 32'h4000_4001);
    chk("t1_bytes", obs[3], 32'(64 + 4 * SEQW));
    chk("t1_first", obs[4 + SEQW], 32'h1);
    chk("t1_last", obs[19 + SEQW], 32'h10);
    chk("t1_en_cyc", 32'(len_log[0]), 32'(20 + SEQW));
    chk("t1_pkts", 32'(pkt_count), 32'd1);

    // Flush-triggered partial packet; flush on empty FIFO is ignored.
    clear_logs();
    write_words(3, 32'h200, ff);
    do_flush();
    drain(200);
    chk("t2_bytes", bytes_log[0], 32'(12 + 4 * SEQW));
    chk("t2_en_cyc", 32'(len_log[0]), 32'(7 + SEQW));
    r0 = req_rises;
    do_flush();
    repeat (50) @(negedge clk);
    chk("t2_empty_flush", 32'(req_rises), 32'(r0));

    // Idle timeout on a single word.
    clear_logs();
    r0 = req_rises;
    write_words(1, 32'h300, ff);
    t = 0;
    while (req_rises == r0 && t < TIMEOUT + 100) begin
      @(negedge clk);
      t++;
    end
    chk("t3_req_seen", 32'(req_rises), 32'(r0 + 1));
    chk("t3_latency", 32'(req_rise_cyc - last_push_cyc), 32'(TIMEOUT));
    drain(200);
    chk("t3_bytes", bytes_log[0], 32'(4 + 4 * SEQW));

    // Fill the FIFO behind a slow grant: 16 + 16 + timeout 8.
    clear_logs();
    ack_tied  = 1'b0;
    ack_delay = 20;
    write_words(40, 32'h400, ff);
    chk("t4_full_at", 32'(ff), 32'd32);
    drain(4000);
    chk("t4_npkts", 32'(len_log.size()), 32'd3);
    chk("t4_len0", 32'(len_log[0]), 32'(20 + SEQW));
    chk("t4_len1", 32'(len_log[1]), 32'(20 + SEQW));
    chk("t4_len2", 32'(len_log[2]), 32'(12 + SEQW));
    ack_tied  = 1'b1;
    ack_delay = 0;

    // Reset in the middle of the payload.
    clear_logs();
    write_words(16, 32'h500, ff);
    t = 0;
    while (!UPLout_Enable && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("t5_en_seen", 32'(UPLout_Enable), 32'd1);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_en", 32'(UPLout_Enable), 32'd0);
    chk("t5_req", 32'(UPLout_Request), 32'd0);
    chk("t5_pkts", 32'(pkt_count), 32'd0);
    chk("t5_rdy", 32'(in_ready), 32'd1);
    r0 = req_rises;
    repeat (TIMEOUT + 50) @(negedge clk);
    chk("t5_no_req", 32'(req_rises), 32'(r0));

    // Two 2-word flush packets after reset.
    clear_logs();
    write_words(2, 32'h600, ff);
    do_flush();
    drain(200);
    write_words(2, 32'h700, ff);
    do_flush();
    drain(200);
    chk("t6_bytes0", bytes_log[0], 32'(8 + 4 * SEQW));
    chk("t6_bytes1", bytes_log[1], 32'(8 + 4 * SEQW));
    chk("t6_pay0", obs[4], (SEQW == 1) ? 32'd0 : 32'h600);
    chk("t6_pay1", obs[10 + SEQW], (SEQW == 1) ? 32'd1 : 32'h700);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

endmodule
